lut_adr_streamer: RTL and testbench

- Sits directly downstream of the 11-bit LUT-address PIO output port.
- Latches the PIO-supplied base address and a burst length on a start edge, then reads a synchronous 2048-entry LUT memory with auto-incrementing addresses.
- Emits the read words as an Avalon-ST packet with valid/ready backpressure into the datapath.

---
 rtl/lut_adr_streamer.sv | 170 +++++++++++++++++
 tb/tb_lut_adr_streamer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_adr_streamer.sv
`default_nettype none
// ============================================================================
// Module   : lut_adr_streamer
// Brief    : Bursts a synchronous LUT from a latched base address into an
//            Avalon-ST packet with valid/ready backpressure.
// Revision : 1.0
// ============================================================================
module lut_adr_streamer #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADR_W-1:0]  lut_adr,
  input  logic [ADR_W-1:0]  lut_len,
  input  logic              start,
  output logic [ADR_W-1:0]  mem_address,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADR_W:0] c_full_len = {1'b1, {ADR_W{1'b0}}};
  localparam logic [ADR_W:0] c_one_len  = {{ADR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_start_q;
  logic              w_start_edge;
  logic              w_latch;
  logic [ADR_W-1:0]  r_cur_adr;
  logic [ADR_W:0]    r_remaining;
  logic              r_first;
  logic              r_done;
  logic              r_inflight;
  logic              r_inflight_sop;
  logic              r_inflight_eop;
  logic [DATA_W-1:0] r_fifo_data [0:1];
  logic [1:0]        r_fifo_sop;
  logic [1:0]        r_fifo_eop;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_head_eop;
  logic [2:0]        w_level;
  logic              w_issue;
  logic              w_last_issue;

  assign w_start_edge = start & ~r_start_q;
  assign w_latch      = (r_state == S_IDLE) && w_start_edge;
  assign w_pop        = (r_count != 2'd0) && src_ready;
  assign w_head_eop   = r_fifo_eop[r_rd_ptr];

  // Occupancy the issued word will meet when it lands; crediting this cycle's
  // pop keeps the pipe at one word per cycle without overflowing two entries.
  assign w_level      = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == S_RUN) && (r_remaining != '0) && (w_level < 3'd2);
  assign w_last_issue = w_issue && (r_remaining == c_one_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_next_state = S_RUN;
      S_RUN:   if (w_last_issue) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pop && w_head_eop) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy              = (r_state != S_IDLE);
    done              = r_done;
    mem_read          = w_issue;
    mem_address       = r_cur_adr;
    src_valid         = (r_count != 2'd0);
    src_data          = r_fifo_data[r_rd_ptr];
    src_startofpacket = r_fifo_sop[r_rd_ptr];
    src_endofpacket   = w_head_eop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q   <= 1'b0;
      r_cur_adr   <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_start_q <= start;
      if (w_latch) begin
        r_cur_adr   <= lut_adr;
        r_remaining <= (lut_len == '0) ? c_full_len : {1'b0, lut_len};
        r_first     <= 1'b1;
        r_done      <= 1'b0;
      end else begin
        if (w_issue) begin
          r_cur_adr   <= r_cur_adr + ADR_W'(1);
          r_remaining <= r_remaining - c_one_len;
          r_first     <= 1'b0;
        end
        if ((r_state == S_DRAIN) && w_pop && w_head_eop) begin
          r_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight     <= 1'b0;
      r_inflight_sop <= 1'b0;
      r_inflight_eop <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_sop <= r_first;
        r_inflight_eop <= w_last_issue;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
      end
      r_fifo_sop <= '0;
      r_fifo_eop <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= mem_readdata;
        r_fifo_sop[r_wr_ptr]  <= r_inflight_sop;
        r_fifo_eop[r_wr_ptr]  <= r_inflight_eop;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_adr_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_adr_streamer
// Brief    : Directed bench for lut_adr_streamer with a read/beat scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lut_adr_streamer;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 11;
  localparam int DEPTH  = 2048;

  logic              clk;
  logic              reset_n;
  logic [ADR_W-1:0]  lut_adr;
  logic [ADR_W-1:0]  lut_len;
  logic              start;
  logic [ADR_W-1:0]  mem_address;
  logic              mem_read;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_startofpacket;
  logic              src_endofpacket;
  logic              busy;
  logic              done;

  lut_adr_streamer #(.DATA_W(DATA_W), .ADR_W(ADR_W)) dut (
    .clk(clk), .reset_n(reset_n), .lut_adr(lut_adr), .lut_len(lut_len),
    .start(start), .mem_address(mem_address), .mem_read(mem_read),
    .mem_readdata(mem_readdata), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket), .busy(busy), .done(done)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  logic [DATA_W-1:0] lut [DEPTH];
  beat_t             exp_q[$];
  logic [ADR_W-1:0]  adr_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issued = 0, accepted = 0;
  int rd_cnt = 0, rd_first = 0, rd_last = 0, beats_seen = 0;
  bit rdy_mode = 0;
  bit hold_prev = 0;
  logic [DATA_W-1:0] prev_data;
  logic prev_sop, prev_eop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < DEPTH; i++) lut[i] = i;
    mem_readdata = '0;
  end

  always @(posedge clk) if (mem_read) mem_readdata <= lut[mem_address];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (hold_prev) begin
        check("hold_valid", src_valid, 1);
        check("hold_data", src_data, prev_data);
        check("hold_sop", src_startofpacket, prev_sop);
        check("hold_eop", src_endofpacket, prev_eop);
      end
      check("outstanding_le2", (issued - accepted) <= 2, 1);
      if (mem_read) begin
        check("read_expected", adr_q.size() > 0, 1);
        if (adr_q.size() > 0) check("mem_address", mem_address, adr_q.pop_front());
        issued++;
        rd_cnt++;
        if (rd_cnt == 1) rd_first = cyc;
        rd_last = cyc;
      end
      if (src_valid && src_ready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("src_data", src_data, b.data);
          check("src_sop", src_startofpacket, b.sop);
          check("src_eop", src_endofpacket, b.eop);
        end
        accepted++;
        beats_seen++;
      end
      hold_prev = src_valid && !src_ready;
      prev_data = src_data;
      prev_sop  = src_startofpacket;
      prev_eop  = src_endofpacket;
    end else begin
      hold_prev = 0;
    end
  end

  initial begin
    src_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      src_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_burst(input logic [ADR_W-1:0] adr, input int len);
    int n;
    n = (len == 0) ? DEPTH : len;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      logic [ADR_W-1:0] a;
      a = ADR_W'((int'(adr) + k) % DEPTH);
      adr_q.push_back(a);
      b.data = lut[a];
      b.sop  = (k == 0);
      b.eop  = (k == n - 1);
      exp_q.push_back(b);
    end
    rd_cnt = 0;
    beats_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    lut_adr = adr;
    lut_len = ADR_W'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int len);
    int n;
    n = 0;
    while (!(done && !busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_in_budget", n < budget, 1);
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
    check("valid_idle", src_valid, 0);
    check("beats_all_seen", exp_q.size(), 0);
    check("reads_all_seen", adr_q.size(), 0);
    check("read_count", rd_cnt, (len == 0) ? DEPTH : len);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_mem_address"}, mem_address, 0);
    check({tag, "_src_valid"}, src_valid, 0);
    check({tag, "_src_data"}, src_data, 0);
    check({tag, "_sop"}, src_startofpacket, 0);
    check({tag, "_eop"}, src_endofpacket, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    lut_adr = '0;
    lut_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Basic 3-word burst: reads must be back to back.
    start_burst(11'h010, 3);
    wait_done(50, 3);
    check("t1_consecutive", rd_last - rd_first, 2);

    // Address wrap across the top of the LUT.
    start_burst(11'h7FE, 4);
    wait_done(50, 4);
    check("t2_consecutive", rd_last - rd_first, 3);

    // Single word: sop and eop together.
    start_burst(11'h123, 1);
    wait_done(50, 1);

    // Random backpressure.
    rdy_mode = 1;
    start_burst(11'h200, 5);
    wait_done(400, 5);
    rdy_mode = 0;

    // Full-depth burst; a mid-burst start edge and input changes are ignored.
    start_burst(11'h000, 0);
    repeat (100) @(posedge clk);
    #1;
    lut_adr = 11'h555;
    lut_len = 11'd7;
    start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    wait_done(3000, 0);

    // Asynchronous reset in the middle of an 8-word burst.
    start_burst(11'h100, 8);
    n = 0;
    while (beats_seen < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_two_beats", beats_seen >= 2, 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    adr_q.delete();
    issued   = 0;
    accepted = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    start_burst(11'h020, 2);
    wait_done(50, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
